// File: rtl/fpadd_issue_ctrl_pkg.sv
// rtl/fpadd_issue_ctrl_pkg.sv - shared constants and FSM state type for the fpadd issue controller
package fpadd_issue_ctrl_pkg;

  localparam int SP_DWIDTH = 32;
  localparam int SP_EWIDTH = 8;
  localparam int SP_MWIDTH = 23;
  localparam int DP_DWIDTH = 64;
  localparam int DP_EWIDTH = 11;
  localparam int DP_MWIDTH = 52;

  localparam int FEX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/fpadd_issue_ctrl_if.sv
// rtl/fpadd_issue_ctrl_if.sv - request, fpadd and result signal bundle around the issue controller
interface fpadd_issue_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int TAGW   = 4
);
  import fpadd_issue_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_a;
  logic [DWIDTH-1:0] in_b;
  logic [TAGW-1:0]   in_tag;

  logic              fa_valid;
  logic [DWIDTH-1:0] fa_a;
  logic [DWIDTH-1:0] fa_b;
  logic [DWIDTH-1:0] fa_sum;
  logic [FEX_W-1:0]  fa_fex;
  logic              fa_done;

  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_sum;
  logic [FEX_W-1:0]  out_fex;
  logic [TAGW-1:0]   out_tag;
  logic              out_tmo;

  logic [FEX_W:0]    flags;
  logic              flags_clr;
  logic              busy;

  modport master (
    input  in_valid, in_a, in_b, in_tag,
    output in_ready,
    output fa_valid, fa_a, fa_b,
    input  fa_sum, fa_fex, fa_done,
    output out_valid, out_sum, out_fex, out_tag, out_tmo,
    input  out_ready,
    output flags, busy,
    input  flags_clr
  );

  modport slave (
    output in_valid, in_a, in_b, in_tag,
    input  in_ready,
    input  fa_valid, fa_a, fa_b,
    output fa_sum, fa_fex, fa_done,
    input  out_valid, out_sum, out_fex, out_tag, out_tmo,
    output out_ready,
    input  flags, busy,
    output flags_clr
  );

endinterface

// File: rtl/fpadd_issue_ctrl_fifo.sv
// rtl/fpadd_issue_ctrl_fifo.sv - operand/tag FIFO, pointers carry an extra wrap bit for full/empty
module fpadd_issue_ctrl_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/fpadd_issue_ctrl.sv
// rtl/fpadd_issue_ctrl.sv - issues queued operand pairs to one fpadd, returns tagged results with timeout and sticky flags
module fpadd_issue_ctrl
  import fpadd_issue_ctrl_pkg::*;
#(
  parameter int DWIDTH  = SP_DWIDTH,
  parameter int DEPTH   = 4,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  fpadd_issue_ctrl_if.master bus
);
  localparam int EW  = 2*DWIDTH + TAGW;
  localparam int TCW = $clog2(TIMEOUT) + 1;
  // Compared before the increment, so the forced completion lands TIMEOUT cycles after the issue pulse.
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 2);
  localparam logic [TCW-1:0] TMO_SAT  = '1;
  localparam logic [TCW-1:0] CNT_ONE  = TCW'(1);

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] fa_a_q, fa_a_d;
  logic [DWIDTH-1:0] fa_b_q, fa_b_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [DWIDTH-1:0] sum_q, sum_d;
  logic [FEX_W-1:0]  fex_q, fex_d;
  logic              tmo_q, tmo_d;
  logic [TCW-1:0]    cnt_q, cnt_d;
  logic [FEX_W:0]    flags_q, flags_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, capture;
  logic [EW-1:0]     fifo_head;

  assign fifo_push = bus.in_valid && !fifo_full;

  fpadd_issue_ctrl_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i ({bus.in_a, bus.in_b, bus.in_tag}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    fa_a_d   = fa_a_q;
    fa_b_d   = fa_b_q;
    tag_d    = tag_q;
    sum_d    = sum_q;
    fex_d    = fex_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    capture  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop                = 1'b1;
          {fa_a_d, fa_b_d, tag_d} = fifo_head;
          state_d                 = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (state_q == ST_ISSUE) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else if (cnt_q != TMO_SAT) begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (bus.fa_done) begin
          sum_d   = bus.fa_sum;
          fex_d   = bus.fa_fex;
          tmo_d   = 1'b0;
          capture = 1'b1;
          state_d = ST_HOLD;
        end else if (state_q == ST_WAIT && cnt_q == TMO_LAST) begin
          sum_d   = '0;
          fex_d   = '0;
          tmo_d   = 1'b1;
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A capture in the same cycle as a clear still sets its bits.
    flags_d = (bus.flags_clr ? '0 : flags_q) | (capture ? {tmo_d, fex_d} : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      fa_a_q  <= '0;
      fa_b_q  <= '0;
      tag_q   <= '0;
      sum_q   <= '0;
      fex_q   <= '0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      fa_a_q  <= fa_a_d;
      fa_b_q  <= fa_b_d;
      tag_q   <= tag_d;
      sum_q   <= sum_d;
      fex_q   <= fex_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.fa_valid  = (state_q == ST_ISSUE);
  assign bus.fa_a      = fa_a_q;
  assign bus.fa_b      = fa_b_q;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_sum   = sum_q;
  assign bus.out_fex   = fex_q;
  assign bus.out_tag   = tag_q;
  assign bus.out_tmo   = tmo_q;
  assign bus.flags     = flags_q;
  assign bus.busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// tb/tb_fpadd_issue_ctrl.sv - self-checking bench: behavioural fpadd responder plus scenario tasks
module tb_fpadd_issue_ctrl;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int TMO = 64;
  localparam int DEPTH = 4;

  localparam logic [31:0] B2B_A [4] = '{32'h3F800000, 32'h42200000, 32'h40A00000, 32'hC2480000};
  localparam logic [31:0] B2B_B [4] = '{32'h40000000, 32'h42A00000, 32'hC0A00000, 32'h41A00000};
  localparam logic [31:0] B2B_S [4] = '{32'h40400000, 32'h42F00000, 32'h00000000, 32'hC1F00000};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpadd_issue_ctrl_if #(.DWIDTH(DW), .TAGW(TW)) bus ();

  fpadd_issue_ctrl #(.DWIDTH(DW), .DEPTH(DEPTH), .TAGW(TW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  tag;
  } exp_t;
  exp_t sb[$];

  function automatic real sp2real(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i > e; i--) m = m / 2.0;
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic s;
    int   e;
    real  m;
    logic [22:0] f;
    logic [7:0]  ex;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    f  = 23'(longint'((m - 1.0) * 8388608.0));
    ex = 8'(e + 127);
    return {s, ex, f};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return real2sp(sp2real(a) + sp2real(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    int v;
    v = int'($urandom_range(0, 2000)) - 1000;
    return real2sp(real'(v));
  endfunction

  // Behavioural fpadd: answers fa_valid after rsp_lat cycles (negative = never)
  int          rsp_lat = 1;
  bit          rsp_rand = 1'b0;
  logic [2:0]  rsp_fex = 3'b000;
  int          rsp_cd;
  logic [31:0] rsp_sum;

  initial begin
    bus.fa_done = 1'b0;
    bus.fa_sum  = '0;
    bus.fa_fex  = '0;
    rsp_cd = -1;
    forever begin
      @(posedge clk);
      #1;
      bus.fa_done = 1'b0;
      if (!rst) begin
        rsp_cd = -1;
      end else if (bus.fa_valid) begin
        rsp_cd  = rsp_rand ? int'($urandom_range(0, 4)) : rsp_lat;
        rsp_sum = fadd(bus.fa_a, bus.fa_b);
      end
      if (rsp_cd == 0) begin
        bus.fa_done = 1'b1;
        bus.fa_sum  = rsp_sum;
        bus.fa_fex  = rsp_fex;
      end
      if (rsp_cd >= 0) rsp_cd--;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_tag = t;
    while (!bus.in_ready && k < 200) begin tick(); k++; end
    n_checks++;
    if (!bus.in_ready) begin
      n_fail++;
      $display("FAIL push_wait: in_ready=0 after %0d cycles, required 1", k);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [31:0] s, output logic [2:0] f, output logic [3:0] t, output logic tm);
    int k = 0;
    while (!bus.out_valid && k < 300) begin tick(); k++; end
    n_checks++;
    if (!bus.out_valid) begin
      n_fail++;
      $display("FAIL result_wait: out_valid=0 after %0d cycles, required 1", k);
    end
    s = bus.out_sum;
    f = bus.out_fex;
    t = bus.out_tag;
    tm = bus.out_tmo;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic wait_fa_valid();
    int k = 0;
    while (!bus.fa_valid && k < 20) begin tick(); k++; end
    n_checks++;
    if (!bus.fa_valid) begin
      n_fail++;
      $display("FAIL issue_wait: fa_valid=0 after %0d cycles, required 1", k);
    end
  endtask

  task automatic test_reset();
    logic [3:0] t;
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_busy: in_ready=%b busy=%b, required 1 0", bus.in_ready, bus.busy);
    end
    n_checks++;
    t = {bus.out_valid, bus.fa_valid, bus.out_tmo, |bus.flags};
    if (t !== 4'b0000 || bus.out_sum !== '0 || bus.fa_a !== '0 || bus.out_tag !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ov/fv/tmo/flags=%b sum=%h fa_a=%h tag=%h, required all 0",
               t, bus.out_sum, bus.fa_a, bus.out_tag);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] s; logic [2:0] f; logic [3:0] t; logic tm;
    int k = 0;
    rsp_lat = 2;
    push_op(32'h41200000, 32'h41600000, 4'd1);
    n_checks++;
    if (bus.fa_valid !== 1'b0) begin n_fail++; $display("FAIL single_fv_t1: fa_valid=%b, required 0", bus.fa_valid); end
    tick();
    n_checks++;
    if (bus.fa_valid !== 1'b1) begin n_fail++; $display("FAIL single_fv_t2: fa_valid=%b, required 1", bus.fa_valid); end
    tick();
    n_checks++;
    if (bus.fa_valid !== 1'b0) begin n_fail++; $display("FAIL single_fv_pulse: fa_valid=%b, required 0", bus.fa_valid); end
    while (!bus.fa_done && k < 20) begin tick(); k++; end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_done_lat: out_valid=%b, required 1", bus.out_valid); end
    wait_result(s, f, t, tm);
    n_checks++;
    if (s !== 32'h41C00000 || t !== 4'd1 || tm !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: sum=%h tag=%0d tmo=%b, required 41c00000 1 0", s, t, tm);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_ov_drop: out_valid=%b, required 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s; logic [2:0] f; logic [3:0] t; logic tm;
    logic [31:0] a0, b0;
    rsp_lat = 1;
    bus.out_ready = 1'b0;
    a0 = rand_fp();
    b0 = rand_fp();
    push_op(a0, b0, 4'd0);
    for (int k = 0; k < 30 && !bus.out_valid; k++) tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: in_ready=%b, required 1", i, bus.in_ready); end
      push_op(B2B_A[i], B2B_B[i], 4'(i + 2));
    end
    bus.in_valid = 1'b1;
    bus.in_a = rand_fp();
    bus.in_b = rand_fp();
    bus.in_tag = 4'hF;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_%0d: in_ready=%b, required 0", i, bus.in_ready); end
      tick();
    end
    bus.in_valid = 1'b0;
    wait_result(s, f, t, tm);
    n_checks++;
    if (s !== fadd(a0, b0) || t !== 4'd0) begin
      n_fail++;
      $display("FAIL b2b_op0: sum=%h tag=%0d, required %h 0", s, t, fadd(a0, b0));
    end
    for (int i = 0; i < 4; i++) begin
      wait_result(s, f, t, tm);
      n_checks++;
      if (s !== B2B_S[i] || t !== 4'(i + 2) || tm !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_result_%0d: sum=%h tag=%0d tmo=%b, required %h %0d 0", i, s, t, tm, B2B_S[i], i + 2);
      end
    end
    repeat (4) tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_bypass: busy=%b, required 0", bus.busy); end
  endtask

  task automatic test_hold_stall();
    logic [31:0] a[5], b[5]; logic [3:0] tg[5];
    logic [31:0] s; logic [2:0] f; logic [3:0] t; logic tm;
    logic [31:0] snap_s; logic [3:0] snap_t;
    rsp_lat = 1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a[i] = rand_fp();
      b[i] = rand_fp();
      tg[i] = 4'($urandom);
      push_op(a[i], b[i], tg[i]);
    end
    for (int k = 0; k < 30 && !bus.out_valid; k++) tick();
    snap_s = bus.out_sum;
    snap_t = bus.out_tag;
    n_checks++;
    if (snap_s !== fadd(a[0], b[0]) || snap_t !== tg[0]) begin
      n_fail++;
      $display("FAIL stall_first: sum=%h tag=%0d, required %h %0d", snap_s, snap_t, fadd(a[0], b[0]), tg[0]);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full: in_ready=%b, required 0", bus.in_ready); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== snap_s || bus.out_tag !== snap_t || bus.fa_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_stable_%0d: ov=%b sum=%h tag=%0d fv=%b, required 1 %h %0d 0",
                 i, bus.out_valid, bus.out_sum, bus.out_tag, bus.fa_valid, snap_s, snap_t);
      end
    end
    wait_result(s, f, t, tm);
    tick();
    n_checks++;
    if (bus.fa_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release_issue: fa_valid=%b, required 1", bus.fa_valid); end
    for (int i = 1; i < 5; i++) begin
      wait_result(s, f, t, tm);
      n_checks++;
      if (s !== fadd(a[i], b[i]) || t !== tg[i]) begin
        n_fail++;
        $display("FAIL stall_result_%0d: sum=%h tag=%0d, required %h %0d", i, s, t, fadd(a[i], b[i]), tg[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] s; logic [2:0] f; logic [3:0] t; logic tm;
    int n = 0;
    int m = 0;
    bus.flags_clr = 1'b1;
    tick();
    bus.flags_clr = 1'b0;
    rsp_lat = 69;
    rsp_fex = 3'b111;
    bus.out_ready = 1'b0;
    push_op(32'h41200000, 32'h41600000, 4'hA);
    wait_fa_valid();
    while (!bus.out_valid && n < 200) begin tick(); n++; end
    n_checks++;
    if (n != 64) begin n_fail++; $display("FAIL tmo_latency: out_valid after %0d cycles, required 64", n); end
    n_checks++;
    if (bus.out_sum !== 32'h0 || bus.out_tmo !== 1'b1 || bus.out_fex !== 3'b000 || bus.out_tag !== 4'hA) begin
      n_fail++;
      $display("FAIL tmo_result: sum=%h tmo=%b fex=%b tag=%h, required 0 1 000 a",
               bus.out_sum, bus.out_tmo, bus.out_fex, bus.out_tag);
    end
    n_checks++;
    if (bus.flags !== 4'b1000) begin n_fail++; $display("FAIL tmo_flags: flags=%b, required 1000", bus.flags); end
    while (!bus.fa_done && m < 20) begin tick(); m++; end
    tick();
    n_checks++;
    if (m != 5 || bus.out_valid !== 1'b1 || bus.out_sum !== 32'h0 || bus.out_fex !== 3'b000 || bus.out_tmo !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_late_done: gap=%0d ov=%b sum=%h fex=%b tmo=%b, required 5 1 0 000 1",
               m, bus.out_valid, bus.out_sum, bus.out_fex, bus.out_tmo);
    end
    wait_result(s, f, t, tm);
    rsp_lat = 1;
    rsp_fex = 3'b000;
  endtask

  task automatic test_flags();
    logic [31:0] s; logic [2:0] f; logic [3:0] t; logic tm;
    bus.flags_clr = 1'b1;
    tick();
    bus.flags_clr = 1'b0;
    rsp_lat = 2;
    rsp_fex = 3'b101;
    push_op(rand_fp(), rand_fp(), 4'h3);
    wait_result(s, f, t, tm);
    n_checks++;
    if (f !== 3'b101 || bus.flags !== 4'b0101) begin
      n_fail++;
      $display("FAIL flags_first: fex=%b flags=%b, required 101 0101", f, bus.flags);
    end
    rsp_fex = 3'b010;
    push_op(rand_fp(), rand_fp(), 4'h6);
    wait_fa_valid();
    tick();
    tick();
    n_checks++;
    if (bus.flags !== 4'b0101) begin n_fail++; $display("FAIL flags_sticky: flags=%b, required 0101", bus.flags); end
    bus.flags_clr = 1'b1;
    tick();
    bus.flags_clr = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_fex !== 3'b010 || bus.flags !== 4'b0010) begin
      n_fail++;
      $display("FAIL flags_clr_set: ov=%b fex=%b flags=%b, required 1 010 0010", bus.out_valid, bus.out_fex, bus.flags);
    end
    wait_result(s, f, t, tm);
    rsp_fex = 3'b000;
    rsp_lat = 1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] s; logic [2:0] f; logic [3:0] t; logic tm;
    logic [31:0] a, b;
    bit seen = 1'b0;
    rsp_lat = -1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_op(rand_fp(), rand_fp(), 4'(i + 8));
    repeat (3) tick();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pre: busy=%b ov=%b, required 1 0", bus.busy, bus.out_valid);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.fa_valid !== 1'b0 ||
        bus.flags !== 4'b0000 || bus.out_tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl: in_ready=%b busy=%b ov=%b fv=%b flags=%b tmo=%b, required 1 0 0 0 0000 0",
               bus.in_ready, bus.busy, bus.out_valid, bus.fa_valid, bus.flags, bus.out_tmo);
    end
    n_checks++;
    if (bus.fa_a !== '0 || bus.fa_b !== '0 || bus.out_sum !== '0 || bus.out_fex !== '0 || bus.out_tag !== '0) begin
      n_fail++;
      $display("FAIL midrst_data: fa_a=%h fa_b=%h sum=%h fex=%b tag=%h, required all 0",
               bus.fa_a, bus.fa_b, bus.out_sum, bus.out_fex, bus.out_tag);
    end
    rst = 1'b1;
    rsp_lat = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.fa_valid || bus.busy) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL midrst_idle: issue/busy seen=1, required 0"); end
    bus.out_ready = 1'b0;
    a = rand_fp();
    b = rand_fp();
    push_op(a, b, 4'h5);
    wait_result(s, f, t, tm);
    n_checks++;
    if (s !== fadd(a, b) || t !== 4'h5) begin
      n_fail++;
      $display("FAIL midrst_new_op: sum=%h tag=%0d, required %h 5", s, t, fadd(a, b));
    end
  endtask

  task automatic test_random();
    localparam int N = 24;
    int got = 0;
    int guard = 0;
    exp_t e;
    sb.delete();
    rsp_rand = 1'b1;
    fork
      begin
        logic [31:0] a, b;
        logic [3:0]  tg;
        for (int i = 0; i < N; i++) begin
          int w = 0;
          repeat ($urandom_range(0, 2)) tick();
          a = rand_fp();
          b = rand_fp();
          tg = 4'($urandom);
          bus.in_valid = 1'b1;
          bus.in_a = a;
          bus.in_b = b;
          bus.in_tag = tg;
          while (!bus.in_ready && w < 300) begin tick(); w++; end
          sb.push_back('{fadd(a, b), tg});
          tick();
          bus.in_valid = 1'b0;
        end
      end
      begin
        while (got < N && guard < 4000) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          if (bus.out_valid && bus.out_ready) begin
            e = (sb.size() > 0) ? sb.pop_front() : '{32'hDEADBEEF, 4'h0};
            n_checks++;
            if (bus.out_sum !== e.sum || bus.out_tag !== e.tag || bus.out_tmo !== 1'b0) begin
              n_fail++;
              $display("FAIL random_%0d: sum=%h tag=%0d tmo=%b, required %h %0d 0",
                       got, bus.out_sum, bus.out_tag, bus.out_tmo, e.sum, e.tag);
            end
            got++;
          end
          tick();
          guard++;
        end
        bus.out_ready = 1'b0;
      end
    join
    rsp_rand = 1'b0;
    n_checks++;
    if (got != N) begin n_fail++; $display("FAIL random_count: results=%0d, required %0d", got, N); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    bus.flags_clr = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_stall();
    test_timeout();
    test_flags();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
